// File: rtl/mmio_pkg.sv
// Shared widths, FSM state type and the slot-range helper for the MMIO slot bus.
package mmio_pkg;

   localparam int SLOT_IDX_W = 5;
   localparam int REG_IDX_W  = 5;
   localparam int DATA_W     = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } mmio_state_t;

   // True when the slot index does not address an attached slot.
   function automatic logic slot_out_of_range(input logic [SLOT_IDX_W-1:0] idx,
                                              input int num_slots);
      return int'(idx) >= num_slots;
   endfunction

endpackage

// File: rtl/mmio_slot_decoder.sv
// Slot index to one-hot chip-select decoder with an out-of-range flag.
// An out-of-range index yields an all-zero select vector.
module mmio_slot_decoder
   import mmio_pkg::*;
#(
   parameter int NUM_SLOTS = 16
) (
   input  logic [SLOT_IDX_W-1:0] idx,
   input  logic                  en,
   output logic [NUM_SLOTS-1:0]  cs,
   output logic                  out_of_range
);

   assign out_of_range = slot_out_of_range(idx, NUM_SLOTS);

   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_cs
      assign cs[gi] = en && (idx == SLOT_IDX_W'(gi));
   end

endmodule

// File: rtl/mmio_slot_ctrl.sv
// MMIO bus master for the peripheral slots: accepts one command in IDLE,
// strobes the addressed slot for one ACCESS cycle, then acknowledges in RESP.
module mmio_slot_ctrl
   import mmio_pkg::*;
#(
   parameter int NUM_SLOTS = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            mmio_req,
   input  logic                            mmio_wr,
   input  logic [SLOT_IDX_W+REG_IDX_W-1:0] mmio_addr,
   input  logic [DATA_W-1:0]               mmio_wr_data,
   output logic                            mmio_ack,
   output logic [DATA_W-1:0]               mmio_rd_data,
   output logic                            mmio_err,
   output logic [NUM_SLOTS-1:0]            slot_cs,
   output logic                            slot_read,
   output logic                            slot_write,
   output logic [REG_IDX_W-1:0]            slot_addr,
   output logic [DATA_W-1:0]               slot_wr_data,
   input  logic [DATA_W*NUM_SLOTS-1:0]     slot_rd_data
);

   localparam int MAX_SLOTS = 2 ** SLOT_IDX_W;

   mmio_state_t state_reg, state_next;
   logic accept;

   logic                  wr_reg;
   logic                  err_reg;
   logic [SLOT_IDX_W-1:0] idx_reg;
   logic [REG_IDX_W-1:0]  addr_reg;
   logic [DATA_W-1:0]     wdata_reg;
   logic [DATA_W-1:0]     rd_reg;
   logic [NUM_SLOTS-1:0]  cs_reg;

   logic [NUM_SLOTS-1:0]  cs_decoded;
   logic                  idx_bad;
   logic [DATA_W-1:0]     rd_word [MAX_SLOTS];

   // The select vector is decoded from the incoming index and registered with the command.
   mmio_slot_decoder #(.NUM_SLOTS(NUM_SLOTS)) u_decoder (
      .idx          (mmio_addr[SLOT_IDX_W+REG_IDX_W-1:REG_IDX_W]),
      .en           (mmio_req),
      .cs           (cs_decoded),
      .out_of_range (idx_bad)
   );

   // Unpack slot read data; unattached indices read as zero so the mux never selects out of range.
   for (genvar gi = 0; gi < MAX_SLOTS; gi++) begin : g_rd
      if (gi < NUM_SLOTS) begin : g_att
         assign rd_word[gi] = slot_rd_data[gi*DATA_W +: DATA_W];
      end else begin : g_none
         assign rd_word[gi] = '0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next state and all state-decoded outputs.
   always_comb begin
      state_next   = state_reg;
      accept       = 1'b0;
      slot_cs      = '0;
      slot_read    = 1'b0;
      slot_write   = 1'b0;
      mmio_ack     = 1'b0;
      mmio_err     = 1'b0;
      mmio_rd_data = '0;
      case (state_reg)
         IDLE: begin
            if (mmio_req) begin
               accept     = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            slot_cs    = cs_reg;
            slot_read  = !err_reg && !wr_reg;
            slot_write = !err_reg && wr_reg;
            state_next = RESP;
         end
         RESP: begin
            mmio_ack     = 1'b1;
            mmio_err     = err_reg;
            mmio_rd_data = rd_reg;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Command capture on acceptance; read data capture at the end of ACCESS.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_reg    <= 1'b0;
         err_reg   <= 1'b0;
         idx_reg   <= '0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         cs_reg    <= '0;
         rd_reg    <= '0;
      end else begin
         if (accept) begin
            wr_reg    <= mmio_wr;
            err_reg   <= idx_bad;
            idx_reg   <= mmio_addr[SLOT_IDX_W+REG_IDX_W-1:REG_IDX_W];
            addr_reg  <= mmio_addr[REG_IDX_W-1:0];
            wdata_reg <= mmio_wr_data;
            cs_reg    <= cs_decoded;
         end
         if (state_reg == ACCESS) begin
            rd_reg <= (!err_reg && !wr_reg) ? rd_word[idx_reg] : '0;
         end
      end
   end

   assign slot_addr    = addr_reg;
   assign slot_wr_data = wdata_reg;

endmodule

// File: tb/tb_mmio_slot_ctrl.sv
// Scoreboard bench for mmio_slot_ctrl: a driver pushes expected strobes and
// acks, a monitor pops them as the DUT presents them. Slot 0 is a timer model,
// slots 1..NS-1 are plain register files.
module tb_mmio_slot_ctrl;

   localparam int NS = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            mmio_req = 1'b0;
   logic            mmio_wr = 1'b0;
   logic [9:0]      mmio_addr = '0;
   logic [31:0]     mmio_wr_data = '0;
   logic            mmio_ack;
   logic [31:0]     mmio_rd_data;
   logic            mmio_err;
   logic [NS-1:0]   slot_cs;
   logic            slot_read;
   logic            slot_write;
   logic [4:0]      slot_addr;
   logic [31:0]     slot_wr_data;
   logic [32*NS-1:0] slot_rd_data;

   mmio_slot_ctrl #(.NUM_SLOTS(NS)) dut (
      .clk          (clk),
      .reset        (reset),
      .mmio_req     (mmio_req),
      .mmio_wr      (mmio_wr),
      .mmio_addr    (mmio_addr),
      .mmio_wr_data (mmio_wr_data),
      .mmio_ack     (mmio_ack),
      .mmio_rd_data (mmio_rd_data),
      .mmio_err     (mmio_err),
      .slot_cs      (slot_cs),
      .slot_read    (slot_read),
      .slot_write   (slot_write),
      .slot_addr    (slot_addr),
      .slot_wr_data (slot_wr_data),
      .slot_rd_data (slot_rd_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- slot models ----------------
   bit [31:0] dev_mem  [NS][32];
   bit        dev_flag [NS][32];
   bit [31:0] tmr_cnt;
   bit        tmr_go;

   function automatic logic [31:0] pat(input int s, input int r);
      logic [7:0] sb, rb;
      sb = s[7:0];
      rb = r[7:0];
      return {16'hCAFE, rb, sb};
   endfunction

   always_comb begin
      slot_rd_data = '0;
      for (int s = 0; s < NS; s++) begin
         if (s == 0) begin
            if (slot_addr == 5'd0)      slot_rd_data[31:0] = tmr_cnt;
            else if (slot_addr == 5'd2) slot_rd_data[31:0] = {31'b0, tmr_go};
         end else begin
            slot_rd_data[s*32 +: 32] = dev_flag[s][slot_addr] ? dev_mem[s][slot_addr]
                                                              : pat(s, int'(slot_addr));
         end
      end
   end

   always @(posedge clk) begin
      for (int s = 1; s < NS; s++) begin
         if (slot_cs[s] && slot_write) begin
            dev_mem[s][slot_addr]  <= slot_wr_data;
            dev_flag[s][slot_addr] <= 1'b1;
         end
      end
      if (slot_cs[0] && slot_write && slot_addr == 5'd2) begin
         if (slot_wr_data[0])  tmr_cnt <= 32'd0;
         else if (tmr_go)      tmr_cnt <= tmr_cnt + 32'd1;
         tmr_go <= slot_wr_data[1];
      end else if (tmr_go) begin
         tmr_cnt <= tmr_cnt + 32'd1;
      end
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      logic [31:0] rd;
      logic        err;
      bit          chk_rd;
   } ack_t;

   typedef struct {
      logic [NS-1:0] cs;
      logic          rd;
      logic          wr;
      logic [4:0]    addr;
      logic [31:0]   wdata;
   } stb_t;

   ack_t        ack_q[$];
   stb_t        stb_q[$];
   logic [31:0] timer_q[$];
   logic [31:0] ref_mem [NS][32];

   // Monitor: pops expectations whenever the DUT shows an ack or a slot strobe.
   always @(negedge clk) begin
      if (reset) begin
         if (mmio_ack) begin
            if (ack_q.size() == 0) begin
               chk("ack_unexpected", 64'(mmio_ack), 64'(0));
            end else begin
               ack_t e;
               e = ack_q.pop_front();
               chk("ack_err", 64'(mmio_err), 64'(e.err));
               if (e.chk_rd) chk("ack_rd_data", 64'(mmio_rd_data), 64'(e.rd));
               else          timer_q.push_back(mmio_rd_data);
            end
         end else begin
            chk("idle_resp", {31'b0, mmio_err, mmio_rd_data}, 64'(0));
         end
         if (slot_cs != '0 || slot_read || slot_write) begin
            if (stb_q.size() == 0) begin
               chk("strobe_unexpected", {slot_cs, slot_read, slot_write}, 64'(0));
            end else begin
               stb_t e;
               e = stb_q.pop_front();
               chk("slot_cs", 64'(slot_cs), 64'(e.cs));
               chk("slot_rw", {slot_read, slot_write}, {e.rd, e.wr});
               chk("slot_addr", 64'(slot_addr), 64'(e.addr));
               if (e.wr) chk("slot_wr_data", 64'(slot_wr_data), 64'(e.wdata));
            end
         end
      end
   end

   // Issue one transaction from a negedge; b2b keeps req high straight after the previous ack.
   task automatic do_txn(input bit wr, input int s, input int r, input logic [31:0] d, input bit b2b);
      ack_t a;
      stb_t t;
      bit   oor;
      int   cnt;
      oor = (s >= NS);
      if (!b2b) begin
         mmio_req = 1'b0;
         @(negedge clk);
      end
      if (!oor) begin
         t.cs    = NS'(1) << s;
         t.rd    = !wr;
         t.wr    = wr;
         t.addr  = 5'(r);
         t.wdata = d;
         stb_q.push_back(t);
      end
      a.err    = oor;
      a.chk_rd = !(s == 0 && !wr);
      a.rd     = (!wr && !oor && s != 0) ? ref_mem[s][r] : 32'd0;
      ack_q.push_back(a);
      if (wr && !oor && s != 0) ref_mem[s][r] = d;
      mmio_req     = 1'b1;
      mmio_wr      = wr;
      mmio_addr    = {5'(s), 5'(r)};
      mmio_wr_data = d;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         // Scramble the command while the DUT is in ACCESS; it must be ignored.
         if (cnt == (b2b ? 2 : 1) && !mmio_ack) begin
            mmio_wr      = 1'($urandom_range(0, 1));
            mmio_addr    = 10'($urandom);
            mmio_wr_data = $urandom;
         end
      end while (!mmio_ack && cnt < 8);
      chk("ack_latency", 64'(cnt), 64'(b2b ? 3 : 2));
      $display("txn wr=%0d slot=%0d reg=%0d data=%08h b2b=%0d ack_after=%0d rd=%08h err=%0d",
               wr, s, r, d, b2b, cnt, mmio_rd_data, mmio_err);
   endtask

   task automatic chk_outputs_zero(input string name);
      chk(name, {slot_cs, slot_read, slot_write, slot_addr, mmio_ack, mmio_err}, 64'(0));
      chk({name, "_data"}, {slot_wr_data, mmio_rd_data}, 64'(0));
   endtask

   initial begin
      for (int s = 0; s < NS; s++)
         for (int r = 0; r < 32; r++)
            ref_mem[s][r] = pat(s, r);

      // Power-on reset
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset_outputs");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Directed cases
      do_txn(1'b1, 3, 2, 32'h1, 1'b0);
      do_txn(1'b0, 5, 0, 32'h0, 1'b0);
      do_txn(1'b0, 16, 1, 32'h0, 1'b0);
      do_txn(1'b0, 31, 31, 32'h0, 1'b0);
      do_txn(1'b0, 15, 31, 32'h0, 1'b0);
      do_txn(1'b1, 1, 4, 32'h1234_5678, 1'b0);
      do_txn(1'b0, 2, 9, 32'h0, 1'b1);
      do_txn(1'b0, 1, 4, 32'h0, 1'b1);

      // Randomized traffic including out-of-range slots
      for (int i = 0; i < 40; i++) begin
         do_txn(1'($urandom_range(0, 1)), int'($urandom_range(1, 19)),
                int'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      end

      // Reset during ACCESS of a write: strobe seen, then dropped with no ack and no write
      mmio_req = 1'b0;
      @(negedge clk);
      begin
         stb_t t;
         t.cs = NS'(1) << 3; t.rd = 1'b0; t.wr = 1'b1; t.addr = 5'd7; t.wdata = 32'hDEAD_BEEF;
         stb_q.push_back(t);
      end
      mmio_req     = 1'b1;
      mmio_wr      = 1'b1;
      mmio_addr    = {5'd3, 5'd7};
      mmio_wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      #2;
      reset    = 1'b0;
      mmio_req = 1'b0;
      #1;
      chk_outputs_zero("reset_async");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_outputs_zero("reset_hold");
      end
      reset = 1'b1;
      $display("reset pulse during write access done");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("post_reset_cs", 64'(slot_cs), 64'(0));
      end
      do_txn(1'b0, 3, 7, 32'h0, 1'b0);

      // Timer: clear+go, then two reads three cycles apart
      do_txn(1'b1, 0, 2, 32'h3, 1'b0);
      do_txn(1'b0, 0, 0, 32'h0, 1'b0);
      do_txn(1'b0, 0, 0, 32'h0, 1'b1);
      mmio_req = 1'b0;
      repeat (4) @(negedge clk);
      chk("timer_reads", 64'(timer_q.size()), 64'(2));
      if (timer_q.size() == 2) begin
         chk("timer_delta", 64'(timer_q[1] - timer_q[0]), 64'(3));
         $display("timer reads %0d then %0d", timer_q[0], timer_q[1]);
      end
      chk("ack_q_empty", 64'(ack_q.size()), 64'(0));
      chk("stb_q_empty", 64'(stb_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
